mem_port_arbiter: RTL and testbench

Two-requester controller for the CPU's single MFA/MFC memory port. It arbitrates between the instruction-fetch path and the data (load/store) path and drives MEMADD, READ_WRITE, WORD_BYTE and the write data. It runs the MFA→MFC→release handshake, returns read data and a one-cycle completion pulse to the granted requester, and aborts with an error flag if memory never answers. It sits between the control unit/datapath and the external memory model.

---
 rtl/mem_port_arbiter_if.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side and memory-side signals of the MFA/MFC port
// arbiter. The slave modport is the arbiter's view; master is the view of
// whatever drives the requests and models the memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  // Fetch requester
  logic              IF_REQ;
  logic [ADDR_W-1:0] IF_ADDR;
  logic              IF_DONE;
  logic [DATA_W-1:0] IF_RDATA;

  // Data (load/store) requester
  logic              DA_REQ;
  logic [ADDR_W-1:0] DA_ADDR;
  logic              DA_RW;
  logic              DA_WB;
  logic [DATA_W-1:0] DA_WDATA;
  logic              DA_DONE;
  logic [DATA_W-1:0] DA_RDATA;
  logic              DA_ERR;

  // Status
  logic              BUSY;

  // Memory port
  logic              MFA;
  logic [ADDR_W-1:0] MEMADD;
  logic              READ_WRITE;
  logic              WORD_BYTE;
  logic [DATA_W-1:0] MEMDAT_OUT;
  logic [DATA_W-1:0] MEMDAT;
  logic              MFC;

  modport slave (
    input  IF_REQ, IF_ADDR,
    input  DA_REQ, DA_ADDR, DA_RW, DA_WB, DA_WDATA,
    input  MEMDAT, MFC,
    output IF_DONE, IF_RDATA,
    output DA_DONE, DA_RDATA, DA_ERR,
    output BUSY,
    output MFA, MEMADD, READ_WRITE, WORD_BYTE, MEMDAT_OUT
  );

  modport master (
    output IF_REQ, IF_ADDR,
    output DA_REQ, DA_ADDR, DA_RW, DA_WB, DA_WDATA,
    output MEMDAT, MFC,
    input  IF_DONE, IF_RDATA,
    input  DA_DONE, DA_RDATA, DA_ERR,
    input  BUSY,
    input  MFA, MEMADD, READ_WRITE, WORD_BYTE, MEMDAT_OUT
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester controller for the single MFA/MFC memory port.
// Arbitrates fetch vs. data (round-robin on ties, data wins the first tie),
// runs the MFA -> MFC -> release handshake, returns read data and a one-cycle
// DONE pulse to the granted requester, and aborts with DA_ERR when memory
// does not answer within TIMEOUT ISSUE cycles.
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic             Clk,
  input logic             Reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]        state;
  logic              last_da;   // last grant: 0 = fetch, 1 = data
  logic              gnt_da;    // current grant: 0 = fetch, 1 = data
  logic              err;       // current transaction timed out
  logic [7:0]        cnt;
  logic [7:0]        cnt_inc;

  logic              mfa;
  logic [ADDR_W-1:0] memadd;
  logic              rw;
  logic              wb;
  logic [DATA_W-1:0] wdata;
  logic              if_done;
  logic              da_done;
  logic              da_err;
  logic [DATA_W-1:0] if_rdata;
  logic [DATA_W-1:0] da_rdata;

  logic              if_req;
  logic              da_req;
  logic              pick_da;

  // Effective requests (a requester is masked while its own DONE is high),
  // round-robin pick, and the saturating timeout increment.
  always_comb begin
    if_req  = bus.IF_REQ & ~if_done;
    da_req  = bus.DA_REQ & ~da_done;
    pick_da = da_req & (~if_req | ~last_da);
    cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  end

  // Handshake state machine with registered bus outputs and completion flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      last_da  <= 1'b0;
      gnt_da   <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
      mfa      <= 1'b0;
      memadd   <= '0;
      rw       <= 1'b1;
      wb       <= 1'b1;
      wdata    <= '0;
      if_done  <= 1'b0;
      da_done  <= 1'b0;
      da_err   <= 1'b0;
      if_rdata <= '0;
      da_rdata <= '0;
    end else begin
      if_done <= 1'b0;
      da_done <= 1'b0;
      da_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req | da_req) begin
            gnt_da <= pick_da;
            mfa    <= 1'b1;
            cnt    <= '0;
            err    <= 1'b0;
            state  <= ISSUE;
            if (pick_da) begin
              memadd <= bus.DA_ADDR;
              rw     <= bus.DA_RW;
              wb     <= bus.DA_WB;
              wdata  <= bus.DA_WDATA;
            end else begin
              memadd <= bus.IF_ADDR;
              rw     <= 1'b1;
              wb     <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.MFC) begin
            if (rw) begin
              if (gnt_da) da_rdata <= bus.MEMDAT;
              else        if_rdata <= bus.MEMDAT;
            end
            mfa   <= 1'b0;
            state <= RELEASE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc >= TIMEOUT_C) begin
              mfa   <= 1'b0;
              err   <= 1'b1;
              state <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (!bus.MFC) state <= DONE;
        end
        DONE: begin
          // The pulse is registered here, so it is visible during the
          // following IDLE cycle; that is why IDLE masks the done requester.
          if_done <= ~gnt_da;
          da_done <= gnt_da;
          da_err  <= err;
          last_da <= gnt_da;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MFA        = mfa;
  assign bus.MEMADD     = memadd;
  assign bus.READ_WRITE = rw;
  assign bus.WORD_BYTE  = wb;
  assign bus.MEMDAT_OUT = wdata;
  assign bus.IF_DONE    = if_done;
  assign bus.IF_RDATA   = if_rdata;
  assign bus.DA_DONE    = da_done;
  assign bus.DA_RDATA   = da_rdata;
  assign bus.DA_ERR     = da_err;
  assign bus.BUSY       = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_if_rdata;
  logic [31:0] exp_da_rdata;

  // {MFA, MEMADD, READ_WRITE, WORD_BYTE, MEMDAT_OUT, IF_DONE, DA_DONE,
  //  IF_RDATA, DA_RDATA, DA_ERR, BUSY}
  localparam logic [110:0] RST_OUTS =
    {1'b0, 8'h00, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  function automatic logic [110:0] outs();
    return {bus.MFA, bus.MEMADD, bus.READ_WRITE, bus.WORD_BYTE, bus.MEMDAT_OUT,
            bus.IF_DONE, bus.DA_DONE, bus.IF_RDATA, bus.DA_RDATA, bus.DA_ERR, bus.BUSY};
  endfunction

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic wait_mfa(input int max_cycles, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int c = 1; c <= max_cycles; c++) begin
      @(negedge Clk);
      if (bus.MFA === 1'b1) begin
        ok = 1'b1;
        cycles = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (outs() !== RST_OUTS) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected %h", outs(), RST_OUTS);
    end
    Reset = 1'b0;
    tick();
    n_cmp++;
    if ({bus.MFA, bus.BUSY} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_no_req: got MFA,BUSY=%b expected 00", {bus.MFA, bus.BUSY});
    end
  endtask

  task automatic test_fetch_read();
    bit ok;
    int cyc;
    bus.IF_ADDR = 8'h00;
    bus.IF_REQ  = 1'b1;
    wait_mfa(4, ok, cyc);
    n_cmp++;
    if (!ok || cyc != 1) begin
      n_bad++;
      $display("FAIL fetch_grant_latency: got ok=%0d cycles=%0d expected ok=1 cycles=1", ok, cyc);
    end
    n_cmp++;
    if ({bus.MEMADD, bus.READ_WRITE, bus.WORD_BYTE} !== {8'h00, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL fetch_bus: got %h expected %h",
               {bus.MEMADD, bus.READ_WRITE, bus.WORD_BYTE}, {8'h00, 1'b1, 1'b1});
    end
    tick();
    tick();
    bus.MFC    = 1'b1;
    bus.MEMDAT = 32'h0000CAFE;
    tick();
    n_cmp++;
    if ({bus.MFA, bus.IF_RDATA} !== {1'b0, 32'h0000CAFE}) begin
      n_bad++;
      $display("FAIL fetch_capture: got MFA=%b IF_RDATA=%h expected MFA=0 IF_RDATA=0000cafe",
               bus.MFA, bus.IF_RDATA);
    end
    bus.MFC    = 1'b0;
    bus.MEMDAT = 32'h0;
    tick();
    n_cmp++;
    if ({bus.IF_DONE, bus.DA_DONE, bus.BUSY} !== 3'b001) begin
      n_bad++;
      $display("FAIL fetch_done_state: got IF_DONE,DA_DONE,BUSY=%b expected 001",
               {bus.IF_DONE, bus.DA_DONE, bus.BUSY});
    end
    tick();
    n_cmp++;
    if ({bus.IF_DONE, bus.DA_DONE, bus.DA_ERR, bus.BUSY} !== 4'b1000) begin
      n_bad++;
      $display("FAIL fetch_done_pulse: got IF_DONE,DA_DONE,DA_ERR,BUSY=%b expected 1000",
               {bus.IF_DONE, bus.DA_DONE, bus.DA_ERR, bus.BUSY});
    end
    bus.IF_REQ = 1'b0;
    tick();
    n_cmp++;
    if ({bus.IF_DONE, bus.MFA, bus.BUSY, bus.IF_RDATA} !== {3'b000, 32'h0000CAFE}) begin
      n_bad++;
      $display("FAIL fetch_after: got IF_DONE,MFA,BUSY=%b IF_RDATA=%h expected 000 0000cafe",
               {bus.IF_DONE, bus.MFA, bus.BUSY}, bus.IF_RDATA);
    end
    exp_if_rdata = 32'h0000CAFE;
  endtask

  task automatic test_byte_store();
    bit ok;
    int cyc;
    bus.DA_ADDR  = 8'h01;
    bus.DA_RW    = 1'b0;
    bus.DA_WB    = 1'b0;
    bus.DA_WDATA = 32'hCAFE0000;
    bus.DA_REQ   = 1'b1;
    wait_mfa(4, ok, cyc);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL store_grant: got no MFA expected MFA within 4 cycles");
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({bus.MFA, bus.MEMADD, bus.READ_WRITE, bus.WORD_BYTE, bus.MEMDAT_OUT} !==
          {1'b1, 8'h01, 1'b0, 1'b0, 32'hCAFE0000}) begin
        n_bad++;
        $display("FAIL store_bus_stable: cycle %0d got %h expected %h", k,
                 {bus.MFA, bus.MEMADD, bus.READ_WRITE, bus.WORD_BYTE, bus.MEMDAT_OUT},
                 {1'b1, 8'h01, 1'b0, 1'b0, 32'hCAFE0000});
      end
      if (k == 2) begin
        bus.MFC    = 1'b1;
        bus.MEMDAT = 32'h11111111;
      end
      tick();
    end
    bus.MFC = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.DA_DONE, bus.IF_DONE, bus.DA_ERR} !== 3'b100) begin
      n_bad++;
      $display("FAIL store_done: got DA_DONE,IF_DONE,DA_ERR=%b expected 100",
               {bus.DA_DONE, bus.IF_DONE, bus.DA_ERR});
    end
    n_cmp++;
    if ({bus.DA_RDATA, bus.IF_RDATA} !== {32'h0, exp_if_rdata}) begin
      n_bad++;
      $display("FAIL store_rdata_unchanged: got DA_RDATA=%h IF_RDATA=%h expected 00000000 %h",
               bus.DA_RDATA, bus.IF_RDATA, exp_if_rdata);
    end
    bus.DA_REQ = 1'b0;
    tick();
    n_cmp++;
    if (bus.DA_DONE !== 1'b0) begin
      n_bad++;
      $display("FAIL store_done_single: got DA_DONE=%b expected 0", bus.DA_DONE);
    end
    exp_da_rdata = 32'h0;
  endtask

  task automatic test_tie_round_robin();
    bit ok;
    int cyc;
    bit exp_da;
    logic [31:0] got_rd;
    Reset = 1'b1;
    tick();
    Reset       = 1'b0;
    bus.IF_ADDR = 8'h10;
    bus.DA_ADDR = 8'h20;
    bus.DA_RW   = 1'b1;
    bus.DA_WB   = 1'b1;
    bus.IF_REQ  = 1'b1;
    bus.DA_REQ  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_da = (i % 2 == 0);
      wait_mfa(4, ok, cyc);
      n_cmp++;
      if (!ok || cyc != 1) begin
        n_bad++;
        $display("FAIL tie_grant_latency: txn %0d got ok=%0d cycles=%0d expected ok=1 cycles=1",
                 i, ok, cyc);
      end
      n_cmp++;
      if (bus.MEMADD !== (exp_da ? 8'h20 : 8'h10)) begin
        n_bad++;
        $display("FAIL tie_grant_order: txn %0d got MEMADD=%h expected %h",
                 i, bus.MEMADD, exp_da ? 8'h20 : 8'h10);
      end
      bus.MFC    = 1'b1;
      bus.MEMDAT = 32'hD0000000 + 32'(i);
      tick();
      bus.MFC = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({bus.IF_DONE, bus.DA_DONE, bus.BUSY, bus.MFA} !== {~exp_da, exp_da, 2'b00}) begin
        n_bad++;
        $display("FAIL tie_done: txn %0d got IF_DONE,DA_DONE,BUSY,MFA=%b expected %b",
                 i, {bus.IF_DONE, bus.DA_DONE, bus.BUSY, bus.MFA}, {~exp_da, exp_da, 2'b00});
      end
      got_rd = exp_da ? bus.DA_RDATA : bus.IF_RDATA;
      n_cmp++;
      if (got_rd !== 32'hD0000000 + 32'(i)) begin
        n_bad++;
        $display("FAIL tie_rdata: txn %0d got %h expected %h", i, got_rd, 32'hD0000000 + 32'(i));
      end
      if (i == 3) begin
        bus.IF_REQ = 1'b0;
        bus.DA_REQ = 1'b0;
      end
    end
    tick();
    n_cmp++;
    if ({bus.BUSY, bus.MFA} !== 2'b00) begin
      n_bad++;
      $display("FAIL tie_idle_after: got BUSY,MFA=%b expected 00", {bus.BUSY, bus.MFA});
    end
    exp_da_rdata = 32'hD0000002;
    exp_if_rdata = 32'hD0000003;
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc;
    int hi;
    bus.DA_ADDR = 8'h30;
    bus.DA_RW   = 1'b1;
    bus.DA_WB   = 1'b1;
    bus.MFC     = 1'b0;
    bus.DA_REQ  = 1'b1;
    wait_mfa(4, ok, cyc);
    hi = ok ? 1 : 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.MFA === 1'b1) hi++;
      else break;
    end
    n_cmp++;
    if (hi != TIMEOUT) begin
      n_bad++;
      $display("FAIL timeout_mfa_width: got %0d cycles expected %0d", hi, TIMEOUT);
    end
    n_cmp++;
    if ({bus.DA_DONE, bus.IF_DONE, bus.BUSY} !== 3'b001) begin
      n_bad++;
      $display("FAIL timeout_release: got DA_DONE,IF_DONE,BUSY=%b expected 001",
               {bus.DA_DONE, bus.IF_DONE, bus.BUSY});
    end
    tick();
    tick();
    n_cmp++;
    if ({bus.DA_DONE, bus.DA_ERR, bus.IF_DONE} !== 3'b110) begin
      n_bad++;
      $display("FAIL timeout_err_pulse: got DA_DONE,DA_ERR,IF_DONE=%b expected 110",
               {bus.DA_DONE, bus.DA_ERR, bus.IF_DONE});
    end
    n_cmp++;
    if (bus.DA_RDATA !== exp_da_rdata) begin
      n_bad++;
      $display("FAIL timeout_rdata_unchanged: got %h expected %h", bus.DA_RDATA, exp_da_rdata);
    end
    bus.DA_REQ = 1'b0;
    tick();
    n_cmp++;
    if ({bus.DA_DONE, bus.DA_ERR} !== 2'b00) begin
      n_bad++;
      $display("FAIL timeout_err_single: got DA_DONE,DA_ERR=%b expected 00",
               {bus.DA_DONE, bus.DA_ERR});
    end
    bus.DA_ADDR = 8'h31;
    bus.DA_REQ  = 1'b1;
    wait_mfa(4, ok, cyc);
    n_cmp++;
    if (!ok || bus.MEMADD !== 8'h31) begin
      n_bad++;
      $display("FAIL after_timeout_grant: got ok=%0d MEMADD=%h expected ok=1 MEMADD=31", ok, bus.MEMADD);
    end
    bus.MFC    = 1'b1;
    bus.MEMDAT = 32'hBEEF0001;
    tick();
    bus.MFC = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.DA_DONE, bus.DA_ERR, bus.DA_RDATA} !== {2'b10, 32'hBEEF0001}) begin
      n_bad++;
      $display("FAIL after_timeout_read: got DA_DONE,DA_ERR=%b DA_RDATA=%h expected 10 beef0001",
               {bus.DA_DONE, bus.DA_ERR}, bus.DA_RDATA);
    end
    bus.DA_REQ = 1'b0;
    tick();
    exp_da_rdata = 32'hBEEF0001;
  endtask

  task automatic test_slow_release();
    bit ok;
    int cyc;
    bus.IF_ADDR  = 8'h44;
    bus.IF_REQ   = 1'b1;
    bus.DA_ADDR  = 8'h45;
    bus.DA_RW    = 1'b0;
    bus.DA_WB    = 1'b1;
    bus.DA_WDATA = 32'h0A0B0C0D;
    bus.DA_REQ   = 1'b1;
    wait_mfa(4, ok, cyc);
    n_cmp++;
    if (!ok || bus.MEMADD !== 8'h44) begin
      n_bad++;
      $display("FAIL slow_grant_fetch: got ok=%0d MEMADD=%h expected ok=1 MEMADD=44", ok, bus.MEMADD);
    end
    bus.MFC    = 1'b1;
    bus.MEMDAT = 32'h12345678;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({bus.MFA, bus.IF_DONE, bus.DA_DONE, bus.BUSY} !== 4'b0001) begin
        n_bad++;
        $display("FAIL slow_hold: cycle %0d got MFA,IF_DONE,DA_DONE,BUSY=%b expected 0001",
                 k, {bus.MFA, bus.IF_DONE, bus.DA_DONE, bus.BUSY});
      end
      if (k == 4) bus.MFC = 1'b0;
      tick();
    end
    n_cmp++;
    if ({bus.MFA, bus.IF_DONE, bus.DA_DONE, bus.BUSY} !== 4'b0001) begin
      n_bad++;
      $display("FAIL slow_no_early_done: got MFA,IF_DONE,DA_DONE,BUSY=%b expected 0001",
               {bus.MFA, bus.IF_DONE, bus.DA_DONE, bus.BUSY});
    end
    tick();
    n_cmp++;
    if ({bus.IF_DONE, bus.DA_DONE, bus.MFA, bus.IF_RDATA} !== {3'b100, 32'h12345678}) begin
      n_bad++;
      $display("FAIL slow_done: got IF_DONE,DA_DONE,MFA=%b IF_RDATA=%h expected 100 12345678",
               {bus.IF_DONE, bus.DA_DONE, bus.MFA}, bus.IF_RDATA);
    end
    bus.IF_REQ = 1'b0;
    tick();
    n_cmp++;
    if ({bus.MFA, bus.MEMADD, bus.READ_WRITE, bus.WORD_BYTE, bus.MEMDAT_OUT} !==
        {1'b1, 8'h45, 1'b0, 1'b1, 32'h0A0B0C0D}) begin
      n_bad++;
      $display("FAIL slow_next_grant: got %h expected %h",
               {bus.MFA, bus.MEMADD, bus.READ_WRITE, bus.WORD_BYTE, bus.MEMDAT_OUT},
               {1'b1, 8'h45, 1'b0, 1'b1, 32'h0A0B0C0D});
    end
    bus.MFC = 1'b1;
    tick();
    bus.MFC = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.DA_DONE, bus.DA_ERR, bus.DA_RDATA} !== {2'b10, exp_da_rdata}) begin
      n_bad++;
      $display("FAIL slow_store_done: got DA_DONE,DA_ERR=%b DA_RDATA=%h expected 10 %h",
               {bus.DA_DONE, bus.DA_ERR}, bus.DA_RDATA, exp_da_rdata);
    end
    bus.DA_REQ = 1'b0;
    tick();
    exp_if_rdata = 32'h12345678;
  endtask

  task automatic test_reset_in_issue();
    bit ok;
    int cyc;
    bus.IF_ADDR = 8'h55;
    bus.IF_REQ  = 1'b1;
    wait_mfa(4, ok, cyc);
    tick();
    n_cmp++;
    if (!ok || bus.MFA !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_issue_setup: got ok=%0d MFA=%b expected ok=1 MFA=1", ok, bus.MFA);
    end
    Reset = 1'b1;
    tick();
    n_cmp++;
    if (outs() !== RST_OUTS) begin
      n_bad++;
      $display("FAIL rst_issue_outputs: got %h expected %h", outs(), RST_OUTS);
    end
    Reset = 1'b0;
    tick();
    n_cmp++;
    if ({bus.MFA, bus.MEMADD, bus.IF_DONE} !== {1'b1, 8'h55, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_issue_regrant: got MFA=%b MEMADD=%h IF_DONE=%b expected 1 55 0",
               bus.MFA, bus.MEMADD, bus.IF_DONE);
    end
    bus.MFC    = 1'b1;
    bus.MEMDAT = 32'h5555AAAA;
    tick();
    bus.MFC = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.IF_DONE, bus.DA_ERR, bus.IF_RDATA} !== {2'b10, 32'h5555AAAA}) begin
      n_bad++;
      $display("FAIL rst_issue_complete: got IF_DONE,DA_ERR=%b IF_RDATA=%h expected 10 5555aaaa",
               {bus.IF_DONE, bus.DA_ERR}, bus.IF_RDATA);
    end
    bus.IF_REQ = 1'b0;
    tick();
  endtask

  initial begin
    bus.IF_REQ   = 1'b0;
    bus.IF_ADDR  = '0;
    bus.DA_REQ   = 1'b0;
    bus.DA_ADDR  = '0;
    bus.DA_RW    = 1'b1;
    bus.DA_WB    = 1'b1;
    bus.DA_WDATA = '0;
    bus.MEMDAT   = '0;
    bus.MFC      = 1'b0;
    exp_if_rdata = '0;
    exp_da_rdata = '0;

    test_reset();
    test_fetch_read();
    test_byte_store();
    test_tie_round_robin();
    test_timeout();
    test_slow_release();
    test_reset_in_issue();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1);
  end

endmodule
